// File: rtl/branch_predict_npc_pkg.sv
// Shared types, opcode constants and IF-stage instruction classifier.
package branch_predict_npc_pkg;

  // Kind of control transfer waiting in ID for resolution
  typedef enum logic [1:0] {
    BHT_KIND_NONE = 2'd0,
    BHT_KIND_BR   = 2'd1,
    BHT_KIND_JR   = 2'd2
  } bht_kind_e;

  // Class of the instruction currently in IF
  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_BR    = 2'd1,
    CLS_JR    = 2'd2,
    CLS_J     = 2'd3
  } if_cls_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [4:0] RT_BLTZ    = 5'd0;
  localparam logic [4:0] RT_BGEZ    = 5'd1;

  function automatic if_cls_e classify(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sh;
    if_cls_e    cls;
    op  = ins[31:26];
    rt  = ins[20:16];
    rd  = ins[15:11];
    sh  = ins[10:6];
    fn  = ins[5:0];
    cls = CLS_OTHER;
    case (op)
      OP_BEQ, OP_BNE:   cls = CLS_BR;
      OP_REGIMM:        if (rt == RT_BLTZ || rt == RT_BGEZ) cls = CLS_BR;
      OP_BLEZ, OP_BGTZ: if (rt == 5'd0) cls = CLS_BR;
      OP_J, OP_JAL:     cls = CLS_J;
      OP_SPECIAL:
        if (rt == 5'd0 && sh == 5'd0 &&
            (fn == FN_JALR || (fn == FN_JR && rd == 5'd0))) cls = CLS_JR;
      default:          cls = CLS_OTHER;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/branch_predict_npc_bht_table.sv
// Branch history table: saturating counters, async read, one registered update.
module branch_predict_npc_bht_table #(
  parameter int IDX_BITS = 4,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_taken_o,
  input  logic                upd_en_i,
  input  logic [IDX_BITS-1:0] upd_idx_i,
  input  logic                upd_inc_i
);
  localparam int                DEPTH    = 2 ** IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  // weak not-taken: MSB clear, all lower bits set
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

  logic [DEPTH-1:0][CTR_BITS-1:0] ctr_q;

  // Read returns the pre-update value; no bypass from a same-cycle update
  assign rd_taken_o = ctr_q[rd_idx_i][CTR_BITS-1];

  // Saturating increment/decrement of the addressed counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
    end else if (upd_en_i) begin
      if (upd_inc_i) begin
        if (ctr_q[upd_idx_i] != CTR_MAX) ctr_q[upd_idx_i] <= ctr_q[upd_idx_i] + 1'b1;
      end else begin
        if (ctr_q[upd_idx_i] != '0) ctr_q[upd_idx_i] <= ctr_q[upd_idx_i] - 1'b1;
      end
    end
  end
endmodule

// File: rtl/branch_predict_npc.sv
// Next-PC generator: IF decode + BHT prediction, ID resolution and redirect.
module branch_predict_npc
  import branch_predict_npc_pkg::*;
#(
  parameter logic [31:0] MAX_INSADDR = 32'hffff_fff8,
  parameter int          IDX_BITS    = 4,
  parameter int          CTR_BITS    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_ins,
  input  logic        id_branch_taken,
  input  logic [31:0] jr_addr,
  output logic [31:0] npc,
  output logic        clr,
  output logic        pred_taken,
  output logic        done
);
  if_cls_e             if_cls;
  logic [31:0]         pc_plus4, br_tgt, j_tgt;
  logic [IDX_BITS-1:0] if_idx;
  logic                ctr_taken;
  logic                mispred, jr_hit;

  bht_kind_e           kind_q;
  logic                pred_q;
  logic [31:0]         tgt_q, fall_q;
  logic [IDX_BITS-1:0] idx_q;

  assign if_cls   = classify(if_ins);
  assign pc_plus4 = if_pc + 32'd4;
  assign br_tgt   = pc_plus4 + {{14{if_ins[15]}}, if_ins[15:0], 2'b00};
  assign j_tgt    = {if_pc[31:28], if_ins[25:0], 2'b00};
  assign if_idx   = if_pc[IDX_BITS+1:2];
  assign done     = (if_pc >= MAX_INSADDR);

  branch_predict_npc_bht_table #(.IDX_BITS(IDX_BITS), .CTR_BITS(CTR_BITS)) u_bht (
    .clk        (clk),
    .rst_n      (rst),
    .rd_idx_i   (if_idx),
    .rd_taken_o (ctr_taken),
    .upd_en_i   (!stall && kind_q == BHT_KIND_BR),
    .upd_idx_i  (idx_q),
    .upd_inc_i  (id_branch_taken)
  );

  assign pred_taken = (if_cls == CLS_BR) && ctr_taken;
  assign mispred    = (kind_q == BHT_KIND_BR) && (id_branch_taken != pred_q);
  assign jr_hit     = (kind_q == BHT_KIND_JR);
  // A stalled redirect waits; it fires on the first unstalled cycle
  assign clr        = !stall && (mispred || jr_hit);

  // Next-PC priority mux: hold, ID redirect, end-of-program, IF prediction
  always_comb begin
    npc = pc_plus4;
    if (stall)                 npc = if_pc;
    else if (mispred)          npc = id_branch_taken ? tgt_q : fall_q;
    else if (jr_hit)           npc = jr_addr;
    else if (done)             npc = if_pc;
    else if (if_cls == CLS_J)  npc = j_tgt;
    else if (pred_taken)       npc = br_tgt;
  end

  // ID record: captures the IF branch/jr for resolution next cycle; a flush squashes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kind_q <= BHT_KIND_NONE;
      pred_q <= 1'b0;
      tgt_q  <= '0;
      fall_q <= '0;
      idx_q  <= '0;
    end else if (!stall) begin
      if (clr)                   kind_q <= BHT_KIND_NONE;
      else if (if_cls == CLS_BR) kind_q <= BHT_KIND_BR;
      else if (if_cls == CLS_JR) kind_q <= BHT_KIND_JR;
      else                       kind_q <= BHT_KIND_NONE;
      pred_q <= pred_taken;
      tgt_q  <= br_tgt;
      fall_q <= pc_plus4;
      idx_q  <= if_idx;
    end
  end
endmodule

// File: tb/tb_branch_predict_npc.sv
// Directed bench: default-parameter DUT plus an IDX_BITS=2/CTR_BITS=3 DUT on shared stimulus.
module tb_branch_predict_npc;
  logic        clk = 1'b0;
  logic        rst, stall, taken;
  logic [31:0] pc, ins, jra;
  logic [31:0] npc1, npc2;
  logic        clr1, clr2, pt1, pt2, done1, done2;
  int          vecs = 0;
  int          fails = 0;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] BEQ3   = {6'h04, 5'd1, 5'd2, 16'd3};
  localparam logic [31:0] JR3    = {6'h00, 5'd3, 5'd0, 5'd0, 5'd0, 6'h08};
  localparam logic [31:0] JRBAD  = {6'h00, 5'd3, 5'd0, 5'd5, 5'd0, 6'h08};
  localparam logic [31:0] J40    = {6'h02, 26'h40};

  always #5 clk = ~clk;

  branch_predict_npc dut1 (
    .clk(clk), .rst(rst), .stall(stall), .if_pc(pc), .if_ins(ins),
    .id_branch_taken(taken), .jr_addr(jra),
    .npc(npc1), .clr(clr1), .pred_taken(pt1), .done(done1));

  branch_predict_npc #(.IDX_BITS(2), .CTR_BITS(3)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .if_pc(pc), .if_ins(ins),
    .id_branch_taken(taken), .jr_addr(jra),
    .npc(npc2), .clr(clr2), .pred_taken(pt2), .done(done2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] i, input logic t);
    pc = p; ins = i; taken = t; #1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; taken = 1'b0; jra = '0;
    drive(32'h10, BEQ3, 1'b0);
    chk("rst_clr", clr1, 0);
    chk("rst_npc", npc1, 32'h14);
    chk("rst_pt", pt1, 0);
    chk("rst_done", done1, 0);
    tick(); tick();
    rst = 1'b1;

    // 1: first BEQ predicted not taken, resolves taken
    drive(32'h10, BEQ3, 1'b0);
    chk("t1_npc", npc1, 32'h14);
    chk("t1_pt", pt1, 0);
    tick();
    drive(32'h14, NOP, 1'b1);
    chk("t1_clr", clr1, 1);
    chk("t1_redir", npc1, 32'h20);
    tick();
    drive(32'h20, NOP, 1'b0);
    chk("t1_flushed", clr1, 0);
    chk("t1_npc2", npc1, 32'h24);
    tick();

    // 2: counter now 2 -> predicted taken, correct, then saturate at 3
    drive(32'h10, BEQ3, 1'b0);
    chk("t2_npc", npc1, 32'h20);
    chk("t2_pt", pt1, 1);
    tick();
    drive(32'h20, NOP, 1'b1);
    chk("t2_noclr", clr1, 0);
    chk("t2_npc2", npc1, 32'h24);
    tick();
    drive(32'h10, BEQ3, 1'b0);
    chk("t2_pt3", pt1, 1);
    tick();
    drive(32'h20, NOP, 1'b1);
    tick();
    drive(32'h10, BEQ3, 1'b0);
    chk("t2_sat", pt1, 1);
    tick();
    drive(32'h20, NOP, 1'b0);
    chk("t2_nt_clr", clr1, 1);
    chk("t2_nt_npc", npc1, 32'h14);
    tick();

    // 8: ctr[4]=2 now; reset in the middle of a mispredict
    drive(32'h10, BEQ3, 1'b0);
    chk("t8_pt", pt1, 1);
    tick();
    drive(32'h20, NOP, 1'b0);
    chk("t8_clr_pre", clr1, 1);
    rst = 1'b0; #1;
    chk("t8_clr_rst", clr1, 0);
    chk("t8_npc_rst", npc1, 32'h24);
    drive(32'h10, BEQ3, 1'b0);
    chk("t8_ctr_init", pt1, 0);
    tick();
    rst = 1'b1;

    // 4: JR in ID held by a two-cycle stall
    drive(32'h100, JR3, 1'b0);
    chk("t4_if_npc", npc1, 32'h104);
    tick();
    stall = 1'b1; jra = 32'h400;
    drive(32'h104, NOP, 1'b0);
    chk("t4_st1_npc", npc1, 32'h104);
    chk("t4_st1_clr", clr1, 0);
    tick();
    chk("t4_st2_npc", npc1, 32'h104);
    chk("t4_st2_clr", clr1, 0);
    tick();
    stall = 1'b0; #1;
    chk("t4_npc", npc1, 32'h400);
    chk("t4_clr", clr1, 1);
    tick();
    drive(32'h400, NOP, 1'b0);
    chk("t4_after", clr1, 0);
    drive(32'h404, JRBAD, 1'b0);
    tick();
    drive(32'h408, NOP, 1'b0);
    chk("t4_jr_rd_clr", clr1, 0);
    chk("t4_jr_rd_npc", npc1, 32'h40c);
    tick();

    // 5: direct jump
    drive(32'h3000_0000, J40, 1'b0);
    chk("t5_npc", npc1, 32'h3000_0100);
    tick();
    drive(32'h3000_0100, NOP, 1'b0);
    chk("t5_clr", clr1, 0);
    chk("t5_npc2", npc1, 32'h3000_0104);
    tick();

    // 6: end-of-program boundary
    drive(32'hffff_fff4, NOP, 1'b0);
    chk("t6_below_done", done1, 0);
    chk("t6_below_npc", npc1, 32'hffff_fff8);
    drive(32'hffff_fff8, NOP, 1'b0);
    chk("t6_done", done1, 1);
    chk("t6_npc", npc1, 32'hffff_fff8);
    tick();

    // 3 and 7 on dut2: fresh reset, counters start at 3
    rst = 1'b0; drive(32'h0, NOP, 1'b0); tick(); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(32'h04, BEQ3, 1'b0);
      chk($sformatf("t3_dec%0d_pt", i), pt2, 0);
      tick();
      drive(32'h08, NOP, 1'b0);
      chk($sformatf("t3_dec%0d_clr", i), clr2, 0);
      tick();
    end
    // from 0, three taken reach 3 (still not-taken); a wrap would predict taken early
    for (int i = 0; i < 4; i++) begin
      drive(32'h04, BEQ3, 1'b0);
      chk($sformatf("t3_inc%0d_pt", i), pt2, 0);
      tick();
      drive(32'h08, NOP, 1'b1);
      chk($sformatf("t3_inc%0d_clr", i), clr2, 1);
      tick();
    end
    // 7: 0x14 aliases 0x04 in the 4-entry table, not in the 16-entry one
    drive(32'h14, BEQ3, 1'b0);
    chk("t7_alias_pt", pt2, 1);
    chk("t7_alias_npc", npc2, 32'h24);
    chk("t7_noalias_pt", pt1, 0);
    chk("t7_noalias_npc", npc1, 32'h18);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
